// File: rtl/i2c_target_regfile.sv
// I2C target exposing a DEPTH x 8 register file with an auto-incrementing pointer.
// Bus signals are synchronized to clk; all protocol decisions run on synchronized edges.
module i2c_target_regfile #(
  parameter logic [6:0] DEVICE_ADDR = 7'h58,
  parameter int         ADDR_BYTES  = 1,
  parameter int         DEPTH       = 256,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [3:0]  state_dbg
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_RADDR, S_RADDR_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      hi_q, hi_d;
  logic [1:0]      ab_q, ab_d;
  logic            rw_q, rw_d, match_q, match_d, ack_q, ack_d;
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic            sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [15:0]     wr_addr_q, wr_addr_d, addr_full;
  logic [7:0]      wr_data_q, wr_data_d, byte_in, rd_byte;
  logic            mem_we;
  logic [7:0]      mem_q [DEPTH];

  // Third stage of each synchronizer holds the previous synced value for edge detection.
  logic scl_meta_q, scl_s_q, scl_p_q, sda_meta_q, sda_s_q, sda_p_q;
  logic scl_rise, scl_fall, start_det, stop_det, shift, done, to_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {scl_meta_q, scl_s_q, scl_p_q} <= 3'b111;
      {sda_meta_q, sda_s_q, sda_p_q} <= 3'b111;
    end else begin
      {scl_meta_q, scl_s_q, scl_p_q} <= {scl_i, scl_meta_q, scl_s_q};
      {sda_meta_q, sda_s_q, sda_p_q} <= {sda_i, sda_meta_q, sda_s_q};
    end
  end

  assign scl_rise  = scl_s_q & ~scl_p_q;
  assign scl_fall  = ~scl_s_q & scl_p_q;
  assign start_det = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

  assign byte_in   = {sr_q[6:0], sda_s_q};
  assign rd_byte   = mem_q[ptr_q];
  assign ptr_inc   = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign addr_full = (ADDR_BYTES == 2) ? {hi_q, byte_in} : {8'h00, byte_in};
  // cnt counts sampled bits; 8 means the byte is complete and the ACK slot is pending.
  assign shift     = scl_rise && (cnt_q != 4'd8);
  assign done      = shift && (cnt_q == 4'd7);
  assign to_ack    = scl_fall && (cnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    hi_d        = hi_q;
    ab_d        = ab_q;
    rw_d        = rw_q;
    match_d     = match_q;
    ack_d       = ack_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    case (state_q)
      S_DEV, S_RADDR, S_WR: begin
        if (shift) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
        end
        if (to_ack) begin
          cnt_d = 4'd0;
        end
        if (done) begin
          if (state_q == S_DEV) begin
            match_d = (byte_in[7:1] == DEVICE_ADDR);
            rw_d    = byte_in[0];
          end else if (state_q == S_RADDR) begin
            if (ab_q == 2'(ADDR_BYTES - 1)) ptr_d = PW'({16'h0000, addr_full} % DEPTH);
            else                            hi_d  = byte_in;
            ab_d = ab_q + 2'd1;
          end else begin
            mem_we      = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = 16'(ptr_q);
            wr_data_d   = byte_in;
            ptr_d       = ptr_inc;
          end
        end
        if (to_ack) begin
          if (state_q == S_DEV && !match_q) begin
            state_d = S_WAIT;
            busy_d  = 1'b0;
          end else begin
            sda_oe_d = 1'b1;
            state_d  = (state_q == S_DEV)   ? S_DEV_ACK :
                       (state_q == S_RADDR) ? S_RADDR_ACK : S_WR_ACK;
          end
        end
      end
      S_DEV_ACK: begin
        if (scl_fall) begin
          cnt_d = 4'd0;
          if (rw_q) begin
            state_d  = S_RD;
            sr_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d  = S_RADDR;
            ab_d     = 2'd0;
            sda_oe_d = 1'b0;
          end
        end
      end
      S_RADDR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = (ab_q == 2'(ADDR_BYTES)) ? S_WR : S_RADDR;
        end
      end
      S_WR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = S_WR;
        end
      end
      S_RD: begin
        if (shift) cnt_d = cnt_q + 4'd1;
        if (to_ack) begin
          state_d  = S_RD_ACK;
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
        end else if (scl_fall) begin
          sda_oe_d = ~sr_q[3'd7 - cnt_q[2:0]];
        end
      end
      S_RD_ACK: begin
        // Pointer advances on the 9th SCL rise so the next byte is ready at the fall.
        if (scl_rise) begin
          ack_d = ~sda_s_q;
          ptr_d = ptr_inc;
        end
        if (scl_fall) begin
          if (ack_q) begin
            state_d  = S_RD;
            sr_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d = S_WAIT;
            busy_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d  = S_DEV;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end

    if (!enable) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      ptr_d       = ptr_q;
      mem_we      = 1'b0;
      wr_strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      sr_q        <= 8'h00;
      hi_q        <= 8'h00;
      ab_q        <= 2'd0;
      rw_q        <= 1'b0;
      match_q     <= 1'b0;
      ack_q       <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 16'h0000;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      hi_q        <= hi_d;
      ab_q        <= ab_d;
      rw_q        <= rw_d;
      match_q     <= match_d;
      ack_q       <= ack_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else if (mem_we) begin
      mem_q[ptr_q] <= byte_in;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign state_dbg = state_q;
endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h58: 7-bit target address matched against first byte after START.
REQ-002 Parameter ADDR_BYTES, default 1, legal 1 or 2: register-address bytes following a write-direction device byte, MSB byte first.
REQ-003 Parameter DEPTH, default 256, legal 2..65536: number of 8-bit registers; pointer width PW = clog2(DEPTH).
REQ-004 Parameter RESET_VAL, default 8'h00: value of every register after reset.
REQ-005 CLK  input  1  system clock, at least 16x SCL rate.
REQ-006 RST  input  1  reset; asynchronous and active-high.
REQ-007 enable  input  1  when low, target ignores the bus and releases SDA.
REQ-008 scl_i  input  1  raw SCL.
REQ-009 sda_i  input  1  raw SDA.
REQ-010 sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
REQ-011 wr_strobe  output  1  one-CLK pulse per register written over I2C.
REQ-012 wr_addr  output  16  register index of current wr_strobe (zero-extended).
REQ-013 wr_data  output  8  data of current wr_strobe.
REQ-014 busy  output  1  high from detected START until STOP or NACK-to-idle.

Function
REQ-015 scl_i and sda_i SHALL pass through a 2-flop synchronizer; edges SHALL be detected on synchronized values only.
REQ-016 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high; both SHALL be honoured in any state, START taking effect as repeated START.
REQ-017 States: IDLE, DEV, DEV_ACK, RADDR, RADDR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT; STOP from any state -> IDLE.
REQ-018 Bits SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only on the CLK after an SCL falling edge.
REQ-019 DEV: after 8 bits, address match -> DEV_ACK (sda_oe=1 for the 9th clock); mismatch -> WAIT with sda_oe=0.
REQ-020 R/W=0 -> RADDR collecting ADDR_BYTES bytes, each ACKed; assembled value modulo DEPTH loads pointer after last byte; then WR.
REQ-021 R/W=1 -> RD using current pointer (no address phase); pointer retained across STOP and repeated START.
REQ-022 WR: after 8th bit sampled, register[pointer] <= byte, wr_strobe pulses one CLK with wr_addr=pointer, wr_data=byte, target ACKs, pointer increments.
REQ-023 RD: byte register[pointer] driven MSB first (sda_oe = ~bit); SDA released during 9th clock; master ACK -> pointer increments, next byte; master NACK -> pointer increments, WAIT.
REQ-024 Pointer increment from DEPTH-1 SHALL wrap to 0.
REQ-025 Data bytes beyond the first in a write SHALL auto-increment identically; no limit on burst length.
REQ-026 enable low SHALL force IDLE and sda_oe=0 within one CLK; register contents and pointer unchanged.
REQ-027 STOP or START mid-byte SHALL discard the partial byte; no register write, no wr_strobe.
REQ-028 busy SHALL assert the CLK after START detection; deassert on STOP, mismatch entry to WAIT, or enable low.

Reset
REQ-029 RST high SHALL immediately force state IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all registers=RESET_VAL.
REQ-030 RST mid-transaction SHALL abort it; the target SHALL ignore the bus until the next START after RST deasserts.

Verification
REQ-031 Write 0xB0,0x10,0xA5,0x5A,STOP -> ACK on all 4 bytes; reg[0x10]=0xA5, reg[0x11]=0x5A; two wr_strobe pulses.
REQ-032 Write 0xB0,0x10, repeated START, 0xB1, read 2 bytes ACK/NACK -> returns 0xA5,0x5A; pointer ends 0x12.
REQ-033 DEPTH=256: write 0xB0,0xFF,0x11,0x22 -> reg[0xFF]=0x11, reg[0x00]=0x22 (wrap).
REQ-034 Device byte 0xB2 -> sda_oe stays 0 through the 9th clock; subsequent bytes ignored; no register change.
REQ-035 ADDR_BYTES=2, DEPTH=1024: write 0xB0,0x03,0xFF,0x77 -> reg[0x3FF]=0x77, wr_addr=0x03FF.
REQ-036 STOP after 4 data bits, then RST pulse mid-read -> no write, sda_oe=0 immediately, all registers=RESET_VAL.
